// File: rtl/rv32i_pkg.sv
// rv32i_pkg: definitions shared between the fetch, queue and decode stages.
//   XLEN          - data/address width
//   NOP_INSTR     - canonical bubble, addi x0,x0,0
//   fetch_entry_t - one queued fetch result {pc, pc_plus_4, instruction}
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [31:0]     instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fetch_queue_storage: circular register array holding queued fetch entries.
// Owns the write and read pointers; the caller decides when push/pop fire.
// Ports:
//   clock      - rising-edge clock
//   sync_reset - synchronous active-low reset (pointers to 0)
//   clear      - synchronous flush (pointers to 0), same effect as reset
//   push       - write wr_entry at the write pointer, advance it
//   pop        - advance the read pointer
//   wr_entry   - entry to store
//   rd_entry   - entry at the read pointer (asynchronous array read)
module fetch_queue_storage
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         sync_reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;

  // Contents are never cleared; the top level derives validity from its
  // occupancy count, so stale data behind the read pointer is harmless.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // DEPTH is a power of two, so the natural pointer overflow is the wrap.
  always_ff @(posedge clock) begin
    if (!sync_reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  assign rd_entry = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: instruction queue between fetch and decode.
// Buffers {PC, PC+4, instruction} with valid/ready handshakes on both sides,
// is emptied by an execute redirect (flush_E), and presents a NOP bubble to
// decode whenever nothing is available.
// Ports:
//   clock, sync_reset (synchronous, active-low)
//   valid_F, PC_F, PC_plus_4_F, instruction_F - entry offered by fetch
//   ready_F     - queue can accept (fetch enable); independent of ready_D
//   flush_E     - discard every entry, drop same-cycle enqueue/dequeue
//   valid_D, PC_D, PC_plus_4_D, instruction_D - head entry for decode
//   ready_D     - decode consumes the head
//   occupancy_D - number of stored entries
// Build option: define FETCH_QUEUE_BYPASS_EN to pass an offered entry
// straight to decode when the queue is empty (zero-latency path).
module fetch_decode_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       sync_reset,
  input  logic                       valid_F,
  input  logic [XLEN-1:0]            PC_F,
  input  logic [XLEN-1:0]            PC_plus_4_F,
  input  logic [31:0]                instruction_F,
  output logic                       ready_F,
  input  logic                       flush_E,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [XLEN-1:0]            PC_D,
  output logic [XLEN-1:0]            PC_plus_4_D,
  output logic [31:0]                instruction_D,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_D
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occupancy_reg;
  logic [OCC_W-1:0] occupancy_next;
  logic             stored_valid;
  logic             enq_fire;
  logic             deq_fire;
  logic             push;
  logic             pop;
  logic             bypass_hit;
  fetch_entry_t     wr_entry;
  fetch_entry_t     rd_entry;

  assign stored_valid = (occupancy_reg != '0);
  assign ready_F      = sync_reset && (occupancy_reg != OCC_W'(DEPTH));
  assign enq_fire     = valid_F && ready_F && !flush_E;
  assign deq_fire     = valid_D && ready_D && !flush_E;
  assign wr_entry     = '{pc: PC_F, pc_plus_4: PC_plus_4_F, instruction: instruction_F};

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a live offer: decode sees the fetch entry directly.
  // If decode takes it this cycle it is never written.
  assign bypass_hit = sync_reset && !stored_valid && valid_F && !flush_E;
  assign push       = enq_fire && !(bypass_hit && ready_D);
`else
  assign bypass_hit = 1'b0;
  assign push       = enq_fire;
`endif
  // A bypassed consume must not move the read pointer.
  assign pop = deq_fire && stored_valid;

  always_comb begin
    occupancy_next = occupancy_reg;
    case ({push, pop})
      2'b10:   occupancy_next = occupancy_reg + OCC_W'(1);
      2'b01:   occupancy_next = occupancy_reg - OCC_W'(1);
      default: occupancy_next = occupancy_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sync_reset || flush_E) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clock      (clock),
    .sync_reset (sync_reset),
    .clear      (flush_E),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .rd_entry   (rd_entry)
  );

  // Stored head wins; otherwise bypassed entry; otherwise a NOP bubble.
  always_comb begin
    valid_D       = 1'b0;
    PC_D          = '0;
    PC_plus_4_D   = '0;
    instruction_D = NOP_INSTR;
    if (stored_valid) begin
      valid_D       = 1'b1;
      PC_D          = rd_entry.pc;
      PC_plus_4_D   = rd_entry.pc_plus_4;
      instruction_D = rd_entry.instruction;
    end else if (bypass_hit) begin
      valid_D       = 1'b1;
      PC_D          = PC_F;
      PC_plus_4_D   = PC_plus_4_F;
      instruction_D = instruction_F;
    end
  end

  assign occupancy_D = occupancy_reg;

endmodule
